// File: rtl/hub75_pkg.sv
// ----------------------------------------------------------------------------
// hub75_pkg
//   Shared constants, scan-out state encoding and pixel bit-plane helpers for
//   the HUB75 scan-out block.
//
//   Pixel words are {red, green, blue}, with each channel BITS_PER_COLOUR wide
//   and red in the MSBs. plane_bits() returns bit <plane> of each channel as
//   {r, g, b}.
// ----------------------------------------------------------------------------
package hub75_pkg;

    localparam int PANEL_WIDTH  = 64;
    localparam int SCAN_ROWS    = 16;
    // Two cycles per column, plus two so the last column can be clocked in.
    localparam int SHIFT_CYCLES = 130;

    // Widest pixel word the extraction helpers accept.
    localparam int PIXEL_MAX    = 64;
    localparam int PIXEL_IDX_W  = 6;

    // Channel field positions, counted in channel widths from the LSB.
    localparam int FIELD_BLUE   = 0;
    localparam int FIELD_GREEN  = 1;
    localparam int FIELD_RED    = 2;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        SHOW
    } state_t;

    // Bit position of bit <plane> of channel <field>.
    function automatic logic [PIXEL_IDX_W-1:0] bit_index(
        input int field,
        input int bits_per_colour,
        input int plane
    );
        return PIXEL_IDX_W'(field * bits_per_colour + plane);
    endfunction

    // {r, g, b} bits of one colour plane of a pixel word.
    function automatic logic [2:0] plane_bits(
        input logic [PIXEL_MAX-1:0] pixel,
        input int                   bits_per_colour,
        input int                   plane
    );
        return {pixel[bit_index(FIELD_RED,   bits_per_colour, plane)],
                pixel[bit_index(FIELD_GREEN, bits_per_colour, plane)],
                pixel[bit_index(FIELD_BLUE,  bits_per_colour, plane)]};
    endfunction

endpackage

// File: rtl/hub75_scanout_show_timer.sv
// ----------------------------------------------------------------------------
// hub75_show_timer
//   Loadable down-counter that times the output-enable period of one BCM
//   plane. A load pulse, given in the LATCH cycle, starts a SHOW period of
//   SHOW_BASE << plane cycles.
//
//   Optional feature (macro HUB75_BRIGHTNESS_EN): the length is scaled to
//   ((SHOW_BASE << plane) * brightness) >> 8. A zero result still gives a
//   one-cycle SHOW period, with the output kept dark.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   i_load       in   start a period in the next cycle
//   i_plane      in   plane index that sets the period length
//   i_brightness in   8-bit brightness scale (HUB75_BRIGHTNESS_EN only)
//   o_active     out  output enable should be asserted this cycle
//   o_done       out  this is the last cycle of the period
// ----------------------------------------------------------------------------
module hub75_show_timer #(
    parameter int BITS_PER_COLOUR = 4,
    parameter int SHOW_BASE       = 32,
    parameter int PLANE_W         = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [PLANE_W-1:0] i_plane,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]         i_brightness,
`endif
    output logic               o_active,
    output logic               o_done
);

    // Wide enough to hold the longest period, that of the last plane.
    localparam int CNT_W = $clog2((SHOW_BASE << (BITS_PER_COLOUR - 1)) + 1);

    logic [CNT_W-1:0] r_count;
    logic             r_on;
    logic [CNT_W-1:0] w_base_len;
    logic [CNT_W-1:0] w_len;

    assign w_base_len = CNT_W'(SHOW_BASE) << i_plane;

`ifdef HUB75_BRIGHTNESS_EN
    logic [CNT_W+7:0] w_scaled;
    assign w_scaled = {8'd0, w_base_len} * {{CNT_W{1'b0}}, i_brightness};
    assign w_len    = CNT_W'(w_scaled >> 8);
`else
    assign w_len    = w_base_len;
`endif

    // r_count holds the SHOW cycles left, the current one included.
    // NOTE: state registers are updated with <= so that every register in the
    // block samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_on    <= 1'b0;
        end else if (i_load) begin
            if (w_len == '0) begin
                r_count <= CNT_W'(1);
                r_on    <= 1'b0;
            end else begin
                r_count <= w_len;
                r_on    <= 1'b1;
            end
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
            if (r_count == CNT_W'(1)) begin
                r_on <= 1'b0;
            end
        end
    end

    assign o_active = r_on;
    assign o_done   = (r_count == CNT_W'(1));

endmodule

// File: rtl/hub75_scanout.sv
// ----------------------------------------------------------------------------
// hub75_scanout
//   Reads the display side of the double-buffered panel RAM and drives a
//   1/16-scan HUB75 panel using binary code modulation. Each row is sent once
//   per colour plane, LSB plane first. The sequence for each plane is:
//   SHIFT (130 cycles: 64 columns shifted in), LATCH (1 cycle) and SHOW
//   (SHOW_BASE << plane cycles with OE active).
//
//   Optional feature (macro HUB75_BRIGHTNESS_EN): adds a brightness[7:0] input
//   that scales every SHOW period. It is sampled on entry to LATCH.
//
// Ports:
//   clk               in   system clock, also the RAM read clock
//   reset             in   synchronous, active-high
//   read_addr         out  RAM read address {row[3:0], col[5:0]}
//   read_en           out  RAM read enable, high only in SHIFT
//   read_data_top     in   pixel for panel rows 0-15 (registered RAM output)
//   read_data_bottom  in   pixel for panel rows 16-31 (same timing)
//   hub75_rgb         out  {r1, g1, b1, r2, g2, b2}
//   hub75_clk         out  panel shift clock
//   hub75_latch       out  panel latch strobe
//   hub75_oe_n        out  panel output enable, active low
//   hub75_addr        out  panel row select
//   frame_done        out  one-cycle pulse in the last cycle of a frame
//   brightness        in   SHOW scale factor (HUB75_BRIGHTNESS_EN only)
// ----------------------------------------------------------------------------
module hub75_scanout
    import hub75_pkg::*;
#(
    parameter int BITS_PER_COLOUR = 4,
    parameter int BITS_PER_PIXEL  = 12,
    parameter int SHOW_BASE       = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [9:0]                read_addr,
    output logic                      read_en,
    input  logic [BITS_PER_PIXEL-1:0] read_data_top,
    input  logic [BITS_PER_PIXEL-1:0] read_data_bottom,
    output logic [5:0]                hub75_rgb,
    output logic                      hub75_clk,
    output logic                      hub75_latch,
    output logic                      hub75_oe_n,
    output logic [3:0]                hub75_addr,
    output logic                      frame_done
`ifdef HUB75_BRIGHTNESS_EN
    ,
    input  logic [7:0]                brightness
`endif
);

    localparam int PLANE_W = (BITS_PER_COLOUR > 1) ? $clog2(BITS_PER_COLOUR) : 1;
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS_PER_COLOUR - 1);
    localparam logic [7:0] LAST_K    = 8'(SHIFT_CYCLES - 1);
    localparam logic [7:0] READ_END  = 8'(2 * PANEL_WIDTH);
    localparam logic [3:0] LAST_ROW  = 4'(SCAN_ROWS - 1);

    if (BITS_PER_PIXEL != 3 * BITS_PER_COLOUR || BITS_PER_PIXEL > PIXEL_MAX) begin : g_bad_width
        $error("hub75_scanout: BITS_PER_PIXEL must equal 3*BITS_PER_COLOUR");
    end

    // Scan position.
    state_t             r_state, w_next_state;
    logic [7:0]         r_k, w_next_k;
    logic [3:0]         r_row, w_next_row;
    logic [PLANE_W-1:0] r_plane, w_next_plane;
    // Low in the cycle that follows reset, so that SHIFT k=0 begins on the
    // first cycle after reset is released.
    logic               r_run;

    // Registered panel and RAM outputs.
    logic [9:0]         r_read_addr;
    logic               r_read_en;
    logic [5:0]         r_rgb;
    logic               r_hclk;
    logic               r_latch;
    logic [3:0]         r_hub_addr;

    logic               w_timer_load;
    logic               w_timer_active;
    logic               w_timer_done;
    logic               w_frame_done;

    logic [PIXEL_MAX-1:0] w_top_ext;
    logic [PIXEL_MAX-1:0] w_bot_ext;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_k     = r_k;
        w_next_row   = r_row;
        w_next_plane = r_plane;
        w_timer_load = 1'b0;
        w_frame_done = 1'b0;
        if (r_run) begin
            case (r_state)
                SHIFT: begin
                    if (r_k == LAST_K) begin
                        w_next_state = LATCH;
                        w_next_k     = '0;
                    end else begin
                        w_next_k = r_k + 8'd1;
                    end
                end
                LATCH: begin
                    w_next_state = SHOW;
                    w_timer_load = 1'b1;
                end
                SHOW: begin
                    if (w_timer_done) begin
                        w_next_state = SHIFT;
                        w_next_k     = '0;
                        if (r_plane == LAST_PLANE) begin
                            w_next_plane = '0;
                            if (r_row == LAST_ROW) begin
                                w_next_row   = '0;
                                w_frame_done = 1'b1;
                            end else begin
                                w_next_row = r_row + 4'd1;
                            end
                        end else begin
                            w_next_plane = r_plane + PLANE_W'(1);
                        end
                    end
                end
                default: w_next_state = SHIFT;
            endcase
        end
    end

    // Zero-extended pixel words for the plane extraction helper.
    always_comb begin
        w_top_ext = '0;
        w_bot_ext = '0;
        w_top_ext[BITS_PER_PIXEL-1:0] = read_data_top;
        w_bot_ext[BITS_PER_PIXEL-1:0] = read_data_bottom;
    end

`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0] r_brightness;
`endif

    // ------------------------------------------------------------------
    // State and output registers. The outputs are computed from the
    // next-state values, so each output is a clean flop and already
    // matches the cycle it describes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SHIFT;
            r_k         <= '0;
            r_row       <= '0;
            r_plane     <= '0;
            r_run       <= 1'b0;
            r_read_addr <= '0;
            r_read_en   <= 1'b0;
            r_rgb       <= '0;
            r_hclk      <= 1'b0;
            r_latch     <= 1'b0;
            r_hub_addr  <= '0;
`ifdef HUB75_BRIGHTNESS_EN
            r_brightness <= '0;
`endif
        end else begin
            r_run   <= 1'b1;
            r_state <= w_next_state;
            r_k     <= w_next_k;
            r_row   <= w_next_row;
            r_plane <= w_next_plane;

            r_read_en <= (w_next_state == SHIFT);
            // Column c is addressed in cycles 2c and 2c+1. The address is
            // held after the last column.
            if (w_next_state == SHIFT && w_next_k < READ_END) begin
                r_read_addr <= {w_next_row, w_next_k[6:1]};
            end

            // Rising shift clock in cycle 2c+3, once column c's data is
            // stable on the pins.
            r_hclk  <= (w_next_state == SHIFT) && w_next_k[0] && (w_next_k >= 8'd3);
            r_latch <= (w_next_state == LATCH);

            if (w_next_state == LATCH) begin
                r_hub_addr <= r_row;
`ifdef HUB75_BRIGHTNESS_EN
                r_brightness <= brightness;
`endif
            end

            // RAM data is valid only in odd SHIFT cycles that follow a
            // column read. It is never sampled elsewhere.
            if (r_run && r_state == SHIFT && r_k[0] && r_k < READ_END) begin
                r_rgb <= {plane_bits(w_top_ext, BITS_PER_COLOUR, int'(r_plane)),
                          plane_bits(w_bot_ext, BITS_PER_COLOUR, int'(r_plane))};
            end
        end
    end

    hub75_show_timer #(
        .BITS_PER_COLOUR (BITS_PER_COLOUR),
        .SHOW_BASE       (SHOW_BASE),
        .PLANE_W         (PLANE_W)
    ) u_show_timer (
        .clk          (clk),
        .reset        (reset),
        .i_load       (w_timer_load),
        .i_plane      (r_plane),
`ifdef HUB75_BRIGHTNESS_EN
        .i_brightness (r_brightness),
`endif
        .o_active     (w_timer_active),
        .o_done       (w_timer_done)
    );

    assign read_addr   = r_read_addr;
    assign read_en     = r_read_en;
    assign hub75_rgb   = r_rgb;
    assign hub75_clk   = r_hclk;
    assign hub75_latch = r_latch;
    assign hub75_oe_n  = !w_timer_active;
    assign hub75_addr  = r_hub_addr;
    assign frame_done  = w_frame_done;

endmodule

// File: tb/tb_hub75_scanout.sv
// ----------------------------------------------------------------------------
// tb_hub75_scanout
//   Directed bench for hub75_scanout. A registered RAM model serves pixel
//   data in one of three patterns. Cycle 0 is the first SHIFT cycle after
//   reset is released. Outputs are sampled 1 time unit after each rising
//   clock edge.
// ----------------------------------------------------------------------------
module tb_hub75_scanout;

    logic        clk;
    logic        reset;
    logic [9:0]  read_addr;
    logic        read_en;
    logic [11:0] read_data_top;
    logic [11:0] read_data_bottom;
    logic [5:0]  hub75_rgb;
    logic        hub75_clk;
    logic        hub75_latch;
    logic        hub75_oe_n;
    logic [3:0]  hub75_addr;
    logic        frame_done;
`ifdef HUB75_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    int total = 0;
    int bad   = 0;
    int ram_mode = 0;

    hub75_scanout #(
        .BITS_PER_COLOUR (4),
        .BITS_PER_PIXEL  (12),
        .SHOW_BASE       (32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .read_addr        (read_addr),
        .read_en          (read_en),
        .read_data_top    (read_data_top),
        .read_data_bottom (read_data_bottom),
        .hub75_rgb        (hub75_rgb),
        .hub75_clk        (hub75_clk),
        .hub75_latch      (hub75_latch),
        .hub75_oe_n       (hub75_oe_n),
        .hub75_addr       (hub75_addr),
        .frame_done       (frame_done)
`ifdef HUB75_BRIGHTNESS_EN
        ,
        .brightness       (brightness)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM model: mode 0 solid, mode 1 column index, mode 2 planes.
    always @(posedge clk) begin
        if (read_en) begin
            case (ram_mode)
                0: begin
                    read_data_top    <= 12'hF00;
                    read_data_bottom <= 12'h00F;
                end
                1: begin
                    read_data_top    <= {6'b0, read_addr[5:0]};
                    read_data_bottom <= {read_addr[5:0], 6'b0};
                end
                default: begin
                    read_data_top    <= 12'h842;
                    read_data_bottom <= 12'h124;
                end
            endcase
        end else begin
            read_data_top    <= 12'hxxx;
            read_data_bottom <= 12'hxxx;
        end
    end

    // Expected rgb for mode 2 data (top 0x842, bottom 0x124) on each plane.
    function automatic logic [5:0] plane_pattern(input int p);
        case (p)
            0:       return 6'b000_100;
            1:       return 6'b001_010;
            2:       return 6'b010_001;
            default: return 6'b100_000;
        endcase
    endfunction

    // OE-low cycles and SHOW length for plane p.
    function automatic int oe_cycles(input int p);
`ifdef HUB75_BRIGHTNESS_EN
        return ((32 << p) * int'(brightness)) >> 8;
`else
        return 32 << p;
`endif
    endfunction

    function automatic int show_cycles(input int p);
        return (oe_cycles(p) == 0) ? 1 : oe_cycles(p);
    endfunction

    function automatic int row_cycles();
        int n = 0;
        for (int p = 0; p < 4; p++) n += 131 + show_cycles(p);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampling cycle 0 (first SHIFT cycle).
    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({read_en, read_addr, hub75_rgb, hub75_clk, hub75_latch, hub75_oe_n, hub75_addr, frame_done}
            !== {1'b0, 10'h000, 6'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: en=%b addr=%h rgb=%b clk=%b lat=%b oe_n=%b row=%h fd=%b, required 0 000 000000 0 0 1 0 0",
                     read_en, read_addr, hub75_rgb, hub75_clk, hub75_latch, hub75_oe_n, hub75_addr, frame_done);
        end
        reset = 1'b0;
        tick();
        total++;
        if (read_en !== 1'b1 || read_addr !== 10'h000 || hub75_oe_n !== 1'b1 || hub75_clk !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_cycle0: en=%b addr=%h oe_n=%b clk=%b, required 1 000 1 0",
                     read_en, read_addr, hub75_oe_n, hub75_clk);
        end
    endtask

    // Mode 0: 64 edges of 100_001, latch at 130 with row 0.
    task automatic test_first_row();
        int   edges = 0;
        logic prev_clk = 1'b0;
        logic exp_clk;
        ram_mode = 0;
        do_reset();
        for (int cyc = 0; cyc <= 130; cyc++) begin
            if (cyc > 0) tick();
            exp_clk = (cyc >= 3) && (cyc % 2 == 1) && (cyc <= 129);
            total++;
            if (hub75_clk !== exp_clk) begin
                bad++;
                $display("FAIL first_row_clk cyc=%0d: got %b, required %b", cyc, hub75_clk, exp_clk);
            end
            if (hub75_clk && !prev_clk) begin
                edges++;
                total++;
                if (hub75_rgb !== 6'b100_001) begin
                    bad++;
                    $display("FAIL first_row_rgb cyc=%0d: got %b, required 100001", cyc, hub75_rgb);
                end
            end
            total++;
            if (hub75_latch !== (cyc == 130) || read_en !== (cyc < 130) || hub75_oe_n !== 1'b1) begin
                bad++;
                $display("FAIL first_row_ctrl cyc=%0d: latch=%b en=%b oe_n=%b", cyc, hub75_latch, read_en, hub75_oe_n);
            end
            prev_clk = hub75_clk;
        end
        total++;
        if (hub75_addr !== 4'h0) begin
            bad++;
            $display("FAIL first_row_latch_addr: got %h, required 0", hub75_addr);
        end
        total++;
        if (edges != 64) begin
            bad++;
            $display("FAIL first_row_edges: got %0d, required 64", edges);
        end
    endtask

    // Mode 1: address sequence and plane-0 bits of the column index.
    task automatic test_columns();
        int          edges = 0;
        logic        prev_clk = 1'b0;
        logic [5:0]  c;
        logic [5:0]  exp_rgb;
        ram_mode = 1;
        do_reset();
        for (int cyc = 0; cyc < 130; cyc++) begin
            if (cyc > 0) tick();
            if (cyc % 2 == 0 && cyc < 128) begin
                total++;
                if (read_addr !== 10'(cyc / 2)) begin
                    bad++;
                    $display("FAIL col_addr cyc=%0d: got %h, required %h", cyc, read_addr, cyc / 2);
                end
            end
            if (hub75_clk && !prev_clk) begin
                c = 6'((cyc - 3) / 2);
                exp_rgb = {1'b0, c[4], c[0], c[2], 2'b00};
                edges++;
                total++;
                if (hub75_rgb !== exp_rgb) begin
                    bad++;
                    $display("FAIL col_rgb col=%0d: got %b, required %b", c, hub75_rgb, exp_rgb);
                end
            end
            prev_clk = hub75_clk;
        end
        total++;
        if (edges != 64) begin
            bad++;
            $display("FAIL col_edges: got %0d, required 64", edges);
        end
    endtask

    // Mode 2: one full frame, BCM run lengths, row order and frame_done.
    task automatic test_bcm();
        int   frame_len = 16 * row_cycles();
        int   run_len = 0, run_idx = 0, latch_idx = 0;
        int   oe_low = 0, edges = 0, ren = 0, exp_low = 0;
        logic prev_oe = 1'b1, prev_clk = 1'b0;
        for (int p = 0; p < 4; p++) exp_low += 16 * oe_cycles(p);
        ram_mode = 2;
        do_reset();
        for (int cyc = 0; cyc < frame_len; cyc++) begin
            if (cyc > 0) tick();
            if (hub75_clk && !prev_clk) begin
                edges++;
                total++;
                if (hub75_rgb !== plane_pattern(latch_idx % 4)) begin
                    bad++;
                    $display("FAIL bcm_rgb cyc=%0d: got %b, required %b", cyc, hub75_rgb, plane_pattern(latch_idx % 4));
                end
            end
            if (hub75_latch) begin
                total++;
                if (hub75_addr !== 4'(latch_idx / 4)) begin
                    bad++;
                    $display("FAIL bcm_row cyc=%0d: got %0d, required %0d", cyc, hub75_addr, latch_idx / 4);
                end
                latch_idx++;
            end
            if (!hub75_oe_n) begin
                run_len++;
                oe_low++;
            end else if (!prev_oe) begin
                total++;
                if (run_len != oe_cycles(run_idx % 4)) begin
                    bad++;
                    $display("FAIL bcm_run %0d: got %0d, required %0d", run_idx, run_len, oe_cycles(run_idx % 4));
                end
                run_idx++;
                run_len = 0;
            end
            if (hub75_latch || !hub75_oe_n) begin
                total++;
                if (read_en !== 1'b0) begin
                    bad++;
                    $display("FAIL bcm_read_en_idle cyc=%0d: got %b, required 0", cyc, read_en);
                end
            end
            if (read_en) ren++;
            total++;
            if (frame_done !== (cyc == frame_len - 1)) begin
                bad++;
                $display("FAIL bcm_frame_done cyc=%0d: got %b, required %b", cyc, frame_done, cyc == frame_len - 1);
            end
            prev_oe  = hub75_oe_n;
            prev_clk = hub75_clk;
        end
        total++;
        if (run_len != oe_cycles(3) || oe_low != exp_low) begin
            bad++;
            $display("FAIL bcm_oe_totals: last run %0d total %0d, required %0d and %0d", run_len, oe_low, oe_cycles(3), exp_low);
        end
        total++;
        if (edges != 4096 || ren != 8320 || latch_idx != 64) begin
            bad++;
            $display("FAIL bcm_counts: edges=%0d read_en=%0d latches=%0d, required 4096 8320 64", edges, ren, latch_idx);
        end
    endtask

    // Continues straight after test_bcm: the next frame starts again at row 0.
    task automatic test_frame_wrap();
        tick();
        total++;
        if (read_addr !== 10'h000 || read_en !== 1'b1 || hub75_oe_n !== 1'b1 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL wrap_start: addr=%h en=%b oe_n=%b fd=%b, required 000 1 1 0", read_addr, read_en, hub75_oe_n, frame_done);
        end
        repeat (3) tick();
        total++;
        if (hub75_clk !== 1'b1 || hub75_rgb !== plane_pattern(0) || hub75_addr !== 4'hF) begin
            bad++;
            $display("FAIL wrap_first_edge: clk=%b rgb=%b row=%h, required 1 %b F", hub75_clk, hub75_rgb, plane_pattern(0), hub75_addr);
        end
        repeat (127) tick();
        total++;
        if (hub75_latch !== 1'b1 || hub75_addr !== 4'h0 || read_en !== 1'b0) begin
            bad++;
            $display("FAIL wrap_latch: latch=%b row=%h en=%b, required 1 0 0", hub75_latch, hub75_addr, read_en);
        end
    endtask

    // Reset in the middle of the plane-3 SHOW period of row 7.
    task automatic test_mid_reset();
        int target = 7 * row_cycles() + 4 * 131 + show_cycles(0) + show_cycles(1) + show_cycles(2) + 50;
        int fd_seen = 0;
        int run = 0;
        ram_mode = 2;
        do_reset();
        for (int cyc = 1; cyc <= target; cyc++) begin
            tick();
            if (frame_done) fd_seen++;
        end
        total++;
        if (hub75_oe_n !== 1'b0 || hub75_addr !== 4'h7) begin
            bad++;
            $display("FAIL mid_reset_setup: oe_n=%b row=%h, required 0 7", hub75_oe_n, hub75_addr);
        end
        reset = 1'b1;
        tick();
        total++;
        if (hub75_oe_n !== 1'b1 || hub75_addr !== 4'h0 || read_en !== 1'b0 || hub75_rgb !== 6'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: oe_n=%b row=%h en=%b rgb=%b fd=%b, required 1 0 0 000000 0",
                     hub75_oe_n, hub75_addr, read_en, hub75_rgb, frame_done);
        end
        reset = 1'b0;
        tick();
        total++;
        if (read_en !== 1'b1 || read_addr !== 10'h000) begin
            bad++;
            $display("FAIL mid_reset_restart: en=%b addr=%h, required 1 000", read_en, read_addr);
        end
        repeat (130) tick();
        total++;
        if (hub75_latch !== 1'b1 || hub75_addr !== 4'h0) begin
            bad++;
            $display("FAIL mid_reset_latch: latch=%b row=%h, required 1 0", hub75_latch, hub75_addr);
        end
        for (int i = 0; i < 600; i++) begin
            tick();
            if (frame_done) fd_seen++;
            if (hub75_oe_n) break;
            run++;
        end
        total++;
        if (run != oe_cycles(0)) begin
            bad++;
            $display("FAIL mid_reset_plane0_run: got %0d, required %0d", run, oe_cycles(0));
        end
        total++;
        if (fd_seen != 0) begin
            bad++;
            $display("FAIL mid_reset_frame_done: got %0d pulses, required 0", fd_seen);
        end
    endtask

    initial begin
        reset = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
        brightness = 8'd128;
`endif
        test_reset();
        test_first_row();
        test_columns();
        test_bcm();
        test_frame_wrap();
        test_mid_reset();
`ifdef HUB75_BRIGHTNESS_EN
        brightness = 8'd0;
        test_bcm();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
